td4_sequencer: RTL
==================

TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15; max cycles FETCH waits for imem_ack before ERROR; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run  in  1  level; 1 = free-run instructions back to back.
REQ-005 step  in  1  one-cycle pulse; in IDLE with run=0, execute exactly one instruction.
REQ-006 imem_req  out  1  instruction fetch request; held high until ack.
REQ-007 imem_addr  out  4  fetch address; equals pc.
REQ-008 imem_ack  in  1  fetch complete; imem_data valid this cycle.
REQ-009 imem_data  in  8  instruction; [7:4] opcode, [3:0] immediate.
REQ-010 ir_op  out  4  latched opcode; drives the decoder op input.
REQ-011 ir_im  out  4  latched immediate; drives the ALU immediate.
REQ-012 c_flag  out  4-bit-ALU carry flag, 1 bit; drives the decoder c input.
REQ-013 dec_ld_n  in  4  decoder load pattern, active-low {PC,C(out),B,A}; 1111 = no load.
REQ-014 alu_y  in  4  ALU result; jump target when PC load is selected.
REQ-015 alu_c  in  1  ALU carry-out of the current instruction.
REQ-016 ld_n  out  4  gated register load strobes, active-low, same bit order as dec_ld_n.
REQ-017 pc  out  4  program counter.
REQ-018 retired  out  8  count of executed instructions.
REQ-019 halted  out  1  high in IDLE.
REQ-020 err  out  1  high in ERROR; sticky.

Function
REQ-021 States: IDLE, FETCH, EXEC, ERROR; encoding free.
REQ-022 IDLE -> FETCH when run=1 or step=1; otherwise stay in IDLE.
REQ-023 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, latch ir_op/ir_im from imem_data and go to EXEC next cycle.
REQ-024 FETCH wait counter: clears on entry to FETCH and increments each FETCH cycle without ack; when it reaches TIMEOUT without ack -> ERROR.
REQ-025 imem_ack on the same cycle the counter reaches TIMEOUT counts as success, not ERROR.
REQ-026 imem_ack outside FETCH is ignored.
REQ-027 EXEC lasts exactly one cycle; ld_n = dec_ld_n, where any dec_ld_n bit not equal to 0 (1, X or Z) drives 1.
REQ-028 ld_n = 4'b1111 in every state other than EXEC.
REQ-029 EXEC edge: c_flag <= alu_c unconditionally.
REQ-030 EXEC edge: if gated ld_n[3]=0 then pc <= alu_y, else pc <= pc+1 modulo 16 (15 -> 0).
REQ-031 EXEC edge: retired <= retired+1 modulo 256.
REQ-032 EXEC exit: run=1 -> FETCH; run=0 -> IDLE. A step pulse seen outside IDLE is discarded.
REQ-033 Deasserting run during FETCH or EXEC finishes the current instruction, then enters IDLE.
REQ-034 Instruction latency with ack in the first FETCH cycle: 2 cycles per instruction (FETCH, EXEC).
REQ-035 ERROR: all outputs hold their values except imem_req=0 and ld_n=1111; only rst exits ERROR.
REQ-036 halted = 1 only in IDLE; err = 1 only in ERROR.

Reset
REQ-037 rst=1 at a clock edge forces IDLE, pc=0, ir_op=0, ir_im=0, c_flag=0, retired=0, and clears the FETCH wait counter.
REQ-038 rst takes priority over every other input and over every state, including ERROR and an in-flight fetch.
REQ-039 While rst=1: imem_req=0, ld_n=1111, halted=1, err=0.

Verification
REQ-040 Reset, then run=1 with ack on first FETCH cycle, imem_data=0x35 (MOV A,5), dec_ld_n=1110 -> ld_n=1110 for one cycle, pc 0->1, retired=1, 2 cycles per instruction.
REQ-041 pc=15, non-jump instruction executed -> pc wraps to 0; JMP with dec_ld_n=0111, alu_y=9 -> pc=9 and no increment.
REQ-042 run=0, step pulse in IDLE -> exactly one FETCH+EXEC, retired+1, back to IDLE; step held during EXEC is not replayed.
REQ-043 TIMEOUT=3, ack withheld -> err=1 after 3 FETCH cycles, imem_req=0, ld_n=1111; rst -> IDLE with err=0; ack on the 3rd cycle instead -> EXEC, no error.
REQ-044 alu_c=1 on an ADD instruction -> c_flag=1 after EXEC; next instruction with alu_c=0 -> c_flag=0; dec_ld_n=xxxx -> ld_n=1111.
REQ-045 rst asserted mid-FETCH and mid-EXEC -> next cycle IDLE, pc=0, retired=0, no ld_n strobe.

Source files
------------

// File: rtl/td4_sequencer.sv
// Fetch/execute sequencer for a TD4-style 4-bit CPU: fetches one byte per
// instruction, gates the external decoder's load strobes for one EXEC cycle.
module td4_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [3:0] ir_op,
  output logic [3:0] ir_im,
  output logic       c_flag,
  input  logic [3:0] dec_ld_n,
  input  logic [3:0] alu_y,
  input  logic       alu_c,
  output logic [3:0] ld_n,
  output logic [3:0] pc,
  output logic [7:0] retired,
  output logic       halted,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ERROR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] wait_reg;
  logic [3:0] exec_ld_n;
  logic       in_exec;
  logic       fetch_expired;

  // Only a solid 0 on a decoder bit may fire a load; 1, X or Z all mean "no load".
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ld_gate
      assign exec_ld_n[gi] = (dec_ld_n[gi] === 1'b0) ? 1'b0 : 1'b1;
    end
  endgenerate

  assign in_exec       = (state_reg == S_EXEC) && !rst;
  assign fetch_expired = (wait_reg == WAIT_LAST);

  assign imem_req  = (state_reg == S_FETCH) && !rst;
  assign imem_addr = pc;
  assign ld_n      = in_exec ? exec_ld_n : 4'b1111;
  assign halted    = (state_reg == S_IDLE) || rst;
  assign err       = (state_reg == S_ERROR) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (run || step) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          state_next = S_EXEC;
        end else if (fetch_expired) begin
          state_next = S_ERROR;
        end
      end
      S_EXEC: begin
        state_next = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_next = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state_reg != S_FETCH)) begin
      wait_reg <= 8'd0;
    end else if (!imem_ack) begin
      wait_reg <= wait_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_op   <= 4'd0;
      ir_im   <= 4'd0;
      c_flag  <= 1'b0;
      pc      <= 4'd0;
      retired <= 8'd0;
    end else begin
      if ((state_reg == S_FETCH) && imem_ack) begin
        ir_op <= imem_data[7:4];
        ir_im <= imem_data[3:0];
      end
      if (state_reg == S_EXEC) begin
        c_flag  <= alu_c;
        pc      <= exec_ld_n[3] ? (pc + 4'd1) : alu_y;
        retired <= retired + 8'd1;
      end
    end
  end

endmodule
